rib_rr_xbar: RTL and testbench

RIB_RR_XBAR -- requirements
Module: rib_rr_xbar

---
 rtl/rib_rr_xbar.sv | 204 ++++++++++++++++++++
 tb/tb_rib_rr_xbar.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_rr_xbar.sv
// -----------------------------------------------------------------------------
// rib_rr_xbar
//
// Single-cycle bus crossbar: NUM_M masters share one path to NUM_S slaves.
// A round-robin arbiter picks one requesting master per cycle. Its address
// top SEL_W bits select the slave, and the remaining bits are forwarded.
// Read data returns combinationally in the same cycle. A granted master can
// lock the bus: only it is granted until it drops its request or its lock.
// Accesses to slave indices >= NUM_S are unmapped. They raise a sticky
// per-master error flag.
//
// Ports
//   clk          single clock, rising edge
//   rstn         synchronous active-low reset
//   m_req_i      [NUM_M]      per-master request
//   m_we_i       [NUM_M]      per-master write enable
//   m_lock_i     [NUM_M]      per-master bus-lock request
//   m_addr_i     [NUM_M*32]   packed master addresses (master k at [32k+:32])
//   m_data_i     [NUM_M*32]   packed master write data
//   m_data_o     [NUM_M*32]   packed read data, nonzero only for the grantee
//   m_gnt_o      [NUM_M]      one-hot-or-zero grant
//   hold_flag_o  [NUM_M]      stall: requesting but not granted
//   err_o        [NUM_M]      sticky unmapped-access error
//   err_clr_i    [NUM_M]      per-master error clear (set wins over clear)
//   s_addr_o     [NUM_S*32]   packed slave addresses (select bits zeroed)
//   s_data_o     [NUM_S*32]   packed slave write data
//   s_data_i     [NUM_S*32]   packed slave read data
//   s_we_o       [NUM_S]      per-slave write enable
// -----------------------------------------------------------------------------
module rib_rr_xbar #(
  parameter int NUM_M = 4,
  parameter int NUM_S = 6,
  parameter int SEL_W = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M-1:0]    m_lock_i,
  input  logic [NUM_M*32-1:0] m_addr_i,
  input  logic [NUM_M*32-1:0] m_data_i,
  output logic [NUM_M*32-1:0] m_data_o,
  output logic [NUM_M-1:0]    m_gnt_o,
  output logic [NUM_M-1:0]    hold_flag_o,
  output logic [NUM_M-1:0]    err_o,
  input  logic [NUM_M-1:0]    err_clr_i,
  output logic [NUM_S*32-1:0] s_addr_o,
  output logic [NUM_S*32-1:0] s_data_o,
  input  logic [NUM_S*32-1:0] s_data_i,
  output logic [NUM_S-1:0]    s_we_o
);

  // A single master still needs a 1-bit index; it simply never leaves 0.
  localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_rr_ptr_nxt;
  logic [PTR_W-1:0] r_owner;
  logic [PTR_W-1:0] w_owner_nxt;
  logic [NUM_M-1:0] r_err;

  logic             w_rr_found;
  logic [PTR_W-1:0] w_rr_idx;
  logic             w_gnt_vld;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [NUM_M-1:0] w_gnt_vec;
  logic [NUM_M-1:0] w_err_set;

  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_we;
  logic [31:0]      w_sel;
  logic             w_mapped;
  logic [31:0]      w_slv_addr;
  logic [31:0]      w_rdata;

  // Modular add on master indices; keeps NUM_M that are not powers of two
  // wrapping at NUM_M rather than at 2**PTR_W.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input int k);
    int n;
    n = (int'(p) + k) % NUM_M;
    return n[PTR_W-1:0];
  endfunction

  // Round-robin search: first requester at or after r_rr_ptr.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (!w_rr_found && m_req_i[ptr_add(r_rr_ptr, k)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = ptr_add(r_rr_ptr, k);
      end
    end
  end

  // Arbitration FSM: next state, owner, pointer and the grant itself.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_gnt_vld    = 1'b0;
    w_gnt_idx    = '0;
    case (r_state)
      ST_ARB: begin
        if (w_rr_found) begin
          w_gnt_vld    = 1'b1;
          w_gnt_idx    = w_rr_idx;
          w_rr_ptr_nxt = ptr_add(w_rr_idx, 1);
          if (m_lock_i[w_rr_idx]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_rr_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (m_req_i[r_owner] && m_lock_i[r_owner]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = r_owner;
        end else begin
          // Release cycle is a dead cycle: nobody is granted, and arbitration
          // resumes next cycle just past the former owner.
          w_state_nxt  = ST_ARB;
          w_rr_ptr_nxt = ptr_add(r_owner, 1);
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Master-side mux, slave decode and read-data return.
  always_comb begin
    w_gnt_vec = '0;
    w_addr    = '0;
    w_wdata   = '0;
    w_we      = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      if (w_gnt_vld && (w_gnt_idx == m[PTR_W-1:0])) begin
        w_gnt_vec[m] = 1'b1;
        w_addr       = m_addr_i[m*32 +: 32];
        w_wdata      = m_data_i[m*32 +: 32];
        w_we         = m_we_i[m];
      end
    end

    w_sel      = {{(32-SEL_W){1'b0}}, w_addr[31 -: SEL_W]};
    w_mapped   = w_gnt_vld && (w_sel < 32'(NUM_S));
    w_slv_addr = w_addr & {{SEL_W{1'b0}}, {(32-SEL_W){1'b1}}};

    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = '0;
    w_rdata  = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (w_mapped && (w_sel == 32'(s))) begin
        s_addr_o[s*32 +: 32] = w_slv_addr;
        s_data_o[s*32 +: 32] = w_wdata;
        s_we_o[s]            = w_we;
        w_rdata              = s_data_i[s*32 +: 32];
      end
    end

    m_data_o  = '0;
    w_err_set = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (w_gnt_vec[m]) begin
        m_data_o[m*32 +: 32] = w_rdata;
        w_err_set[m]         = !w_mapped;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rstn) begin
      r_state  <= ST_ARB;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
      // Set term is ORed in after the clear so a same-edge set wins.
      r_err    <= (r_err & ~err_clr_i) | w_err_set;
    end
  end

  assign m_gnt_o     = w_gnt_vec;
  assign hold_flag_o = m_req_i & ~w_gnt_vec;
  assign err_o       = r_err;

endmodule

// File: tb/tb_rib_rr_xbar.sv
// -----------------------------------------------------------------------------
// tb_rib_rr_xbar
//
// Directed bench for rib_rr_xbar (NUM_M=4, NUM_S=6, SEL_W=4). Each stimulus
// cycle pushes its hand-computed expected outputs into a queue. A monitor on
// the falling edge pops one entry per cycle and compares all outputs.
// -----------------------------------------------------------------------------
module tb_rib_rr_xbar;

  localparam int NM = 4;
  localparam int NS = 6;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NM-1:0]    m_req_i = '0;
  logic [NM-1:0]    m_we_i = '0;
  logic [NM-1:0]    m_lock_i = '0;
  logic [NM*32-1:0] m_addr_i = '0;
  logic [NM*32-1:0] m_data_i = '0;
  logic [NM*32-1:0] m_data_o;
  logic [NM-1:0]    m_gnt_o;
  logic [NM-1:0]    hold_flag_o;
  logic [NM-1:0]    err_o;
  logic [NM-1:0]    err_clr_i = '0;
  logic [NS*32-1:0] s_addr_o;
  logic [NS*32-1:0] s_data_o;
  logic [NS*32-1:0] s_data_i;
  logic [NS-1:0]    s_we_o;

  // Fixed slave read data; slave 1 returns A5A5_5A5A.
  assign s_data_i = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003,
                     32'h2222_0002, 32'hA5A5_5A5A, 32'h1111_0000};

  rib_rr_xbar #(.NUM_M(NM), .NUM_S(NS), .SEL_W(SW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_lock_i   (m_lock_i),
    .m_addr_i   (m_addr_i),
    .m_data_i   (m_data_i),
    .m_data_o   (m_data_o),
    .m_gnt_o    (m_gnt_o),
    .hold_flag_o(hold_flag_o),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i),
    .s_addr_o   (s_addr_o),
    .s_data_o   (s_data_o),
    .s_data_i   (s_data_i),
    .s_we_o     (s_we_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   gnt;
    logic [3:0]   hold;
    logic [3:0]   err;
    logic [5:0]   we;
    logic [191:0] saddr;
    logic [191:0] sdata;
    logic [127:0] mdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [127:0] pk4(input logic [31:0] a3, input logic [31:0] a2,
                                       input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [191:0] s6(input int idx, input logic [31:0] v);
    logic [191:0] r;
    r = '0;
    r[idx*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [127:0] m4(input int idx, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[idx*32 +: 32] = v;
    return r;
  endfunction

  task automatic check(input string name, input string field,
                       input logic [191:0] act, input logic [191:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // One stimulus cycle: drive just after the rising edge, queue expectations.
  task automatic cycle(input logic rst_v,
                       input logic [3:0] req, input logic [3:0] we,
                       input logic [3:0] lock, input logic [3:0] clr,
                       input logic [127:0] addr, input logic [127:0] wdata,
                       input string name,
                       input logic [3:0] e_gnt, input logic [3:0] e_hold,
                       input logic [3:0] e_err, input logic [5:0] e_we,
                       input logic [191:0] e_saddr, input logic [191:0] e_sdata,
                       input logic [127:0] e_mdata);
    exp_t e;
    @(posedge clk);
    #1;
    rstn      = rst_v;
    m_req_i   = req;
    m_we_i    = we;
    m_lock_i  = lock;
    err_clr_i = clr;
    m_addr_i  = addr;
    m_data_i  = wdata;
    e.name  = name;
    e.gnt   = e_gnt;
    e.hold  = e_hold;
    e.err   = e_err;
    e.we    = e_we;
    e.saddr = e_saddr;
    e.sdata = e_sdata;
    e.mdata = e_mdata;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every output once per cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "gnt",   {188'b0, m_gnt_o},     {188'b0, e.gnt});
        check(e.name, "hold",  {188'b0, hold_flag_o}, {188'b0, e.hold});
        check(e.name, "err",   {188'b0, err_o},       {188'b0, e.err});
        check(e.name, "s_we",  {186'b0, s_we_o},      {186'b0, e.we});
        check(e.name, "saddr", s_addr_o,              e.saddr);
        check(e.name, "sdata", s_data_o,              e.sdata);
        check(e.name, "mdata", {64'b0, m_data_o},     {64'b0, e.mdata});
      end
    end
  end

  initial begin
    logic [127:0] a_01;
    logic [127:0] a_lk;
    a_01 = pk4(32'h0, 32'h0, 32'h1000_0200, 32'h0000_0100);
    a_lk = pk4(32'h0, 32'h4000_0040, 32'h2000_0020, 32'h0000_0100);

    repeat (2) @(posedge clk);

    // Combinational path during reset uses reset-state registers.
    cycle(1'b0, 4'b0011, 4'b0, 4'b0, 4'b0, a_01, '0, "rst_comb",
          4'b0001, 4'b0010, 4'b0, 6'b0, s6(0, 32'h100), '0, m4(0, 32'h1111_0000));

    // Two continuous requesters alternate.
    cycle(1'b1, 4'b0011, 4'b0, 4'b0, 4'b0, a_01, '0, "alt_1",
          4'b0001, 4'b0010, 4'b0, 6'b0, s6(0, 32'h100), '0, m4(0, 32'h1111_0000));
    cycle(1'b1, 4'b0011, 4'b0, 4'b0, 4'b0, a_01, '0, "alt_2",
          4'b0010, 4'b0001, 4'b0, 6'b0, s6(1, 32'h200), '0, m4(1, 32'hA5A5_5A5A));
    cycle(1'b1, 4'b0011, 4'b0, 4'b0, 4'b0, a_01, '0, "alt_3",
          4'b0001, 4'b0010, 4'b0, 6'b0, s6(0, 32'h100), '0, m4(0, 32'h1111_0000));
    cycle(1'b1, 4'b0011, 4'b0, 4'b0, 4'b0, a_01, '0, "alt_4",
          4'b0010, 4'b0001, 4'b0, 6'b0, s6(1, 32'h200), '0, m4(1, 32'hA5A5_5A5A));

    // Master 2 read from slave 1.
    cycle(1'b1, 4'b0100, 4'b0, 4'b0, 4'b0, pk4(32'h0, 32'h1000_0010, 32'h0, 32'h0), '0,
          "rd_m2", 4'b0100, 4'b0000, 4'b0, 6'b0, s6(1, 32'h10), '0, m4(2, 32'hA5A5_5A5A));

    // Master 3 write to slave 3.
    cycle(1'b1, 4'b1000, 4'b1000, 4'b0, 4'b0, pk4(32'h3000_0004, 32'h0, 32'h0, 32'h0),
          pk4(32'h1234, 32'h0, 32'h0, 32'h0), "wr_m3",
          4'b1000, 4'b0000, 4'b0, 6'b001000, s6(3, 32'h4), s6(3, 32'h1234),
          m4(3, 32'h3333_0003));

    // Pointer at 0: master 1 beats master 3; master 3's we must not leak.
    cycle(1'b1, 4'b1010, 4'b1000, 4'b0, 4'b0, pk4(32'h3000_0004, 32'h0, 32'h5000_0008, 32'h0),
          pk4(32'h1234, 32'h0, 32'hCAFE_0001, 32'h0), "rd_s5",
          4'b0010, 4'b1000, 4'b0, 6'b0, s6(5, 32'h8), s6(5, 32'hCAFE_0001),
          m4(1, 32'h5555_0005));

    // Pointer 2 -> 0 wraps to master 0, leaving pointer at 1.
    cycle(1'b1, 4'b0001, 4'b0, 4'b0, 4'b0, a_lk, '0, "wrap_m0",
          4'b0001, 4'b0000, 4'b0, 6'b0, s6(0, 32'h100), '0, m4(0, 32'h1111_0000));

    // Master 1 locks for 4 cycles while master 0 (and briefly 2) request.
    cycle(1'b1, 4'b0011, 4'b0, 4'b0010, 4'b0, a_lk, '0, "lock_1",
          4'b0010, 4'b0001, 4'b0, 6'b0, s6(2, 32'h20), '0, m4(1, 32'h2222_0002));
    cycle(1'b1, 4'b0011, 4'b0, 4'b0010, 4'b0, a_lk, '0, "lock_2",
          4'b0010, 4'b0001, 4'b0, 6'b0, s6(2, 32'h20), '0, m4(1, 32'h2222_0002));
    cycle(1'b1, 4'b0111, 4'b0, 4'b0010, 4'b0, a_lk, '0, "lock_3",
          4'b0010, 4'b0101, 4'b0, 6'b0, s6(2, 32'h20), '0, m4(1, 32'h2222_0002));
    cycle(1'b1, 4'b0011, 4'b0, 4'b0010, 4'b0, a_lk, '0, "lock_4",
          4'b0010, 4'b0001, 4'b0, 6'b0, s6(2, 32'h20), '0, m4(1, 32'h2222_0002));
    cycle(1'b1, 4'b0001, 4'b0, 4'b0, 4'b0, a_lk, '0, "lock_rel",
          4'b0000, 4'b0001, 4'b0, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0001, 4'b0, 4'b0, 4'b0, a_lk, '0, "after_rel",
          4'b0001, 4'b0000, 4'b0, 6'b0, s6(0, 32'h100), '0, m4(0, 32'h1111_0000));

    // Release by dropping lock while still requesting.
    cycle(1'b1, 4'b0010, 4'b0, 4'b0010, 4'b0, a_lk, '0, "lock_b1",
          4'b0010, 4'b0000, 4'b0, 6'b0, s6(2, 32'h20), '0, m4(1, 32'h2222_0002));
    cycle(1'b1, 4'b0010, 4'b0, 4'b0, 4'b0, a_lk, '0, "lock_b_rel",
          4'b0000, 4'b0010, 4'b0, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0011, 4'b0, 4'b0, 4'b0, a_lk, '0, "lock_b_after",
          4'b0001, 4'b0010, 4'b0, 6'b0, s6(0, 32'h100), '0, m4(0, 32'h1111_0000));

    // Unmapped accesses and sticky error with set-wins-over-clear.
    cycle(1'b1, 4'b0001, 4'b0001, 4'b0, 4'b0, pk4(32'h0, 32'h0, 32'h0, 32'hF000_0000),
          pk4(32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF), "unm_wr",
          4'b0001, 4'b0000, 4'b0000, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0000, 4'b0, 4'b0, 4'b0, '0, '0, "err_set",
          4'b0000, 4'b0000, 4'b0001, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0001, 4'b0, 4'b0, 4'b0001, pk4(32'h0, 32'h0, 32'h0, 32'h6000_0000), '0,
          "unm_clr", 4'b0001, 4'b0000, 4'b0001, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0000, 4'b0, 4'b0, 4'b0, '0, '0, "err_kept",
          4'b0000, 4'b0000, 4'b0001, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0000, 4'b0, 4'b0, 4'b0001, '0, '0, "err_clr",
          4'b0000, 4'b0000, 4'b0001, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0000, 4'b0, 4'b0, 4'b0, '0, '0, "err_gone",
          4'b0000, 4'b0000, 4'b0000, 6'b0, '0, '0, '0);

    // Reset during LOCKED: error on master 3, lock by master 2, then reset.
    cycle(1'b1, 4'b1000, 4'b0, 4'b0, 4'b0, pk4(32'hF000_0000, 32'h0, 32'h0, 32'h0), '0,
          "unm_m3", 4'b1000, 4'b0000, 4'b0000, 6'b0, '0, '0, '0);
    cycle(1'b1, 4'b0100, 4'b0, 4'b0100, 4'b0, pk4(32'hF000_0000, 32'h4000_0040, 32'h0, 32'h0),
          '0, "lock_m2", 4'b0100, 4'b0000, 4'b1000, 6'b0, s6(4, 32'h40), '0,
          m4(2, 32'h4444_0004));
    cycle(1'b0, 4'b1100, 4'b0, 4'b0100, 4'b0, pk4(32'hF000_0000, 32'h4000_0040, 32'h0, 32'h0),
          '0, "rst_locked", 4'b0100, 4'b1000, 4'b1000, 6'b0, s6(4, 32'h40), '0,
          m4(2, 32'h4444_0004));
    cycle(1'b1, 4'b1010, 4'b0, 4'b0, 4'b0, pk4(32'hF000_0000, 32'h0, 32'h0000_0100, 32'h0),
          '0, "post_rst", 4'b0010, 4'b1000, 4'b0000, 6'b0, s6(0, 32'h100), '0,
          m4(1, 32'h1111_0000));

    // Let the monitor drain, bounded.
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
